// File: rtl/pe_pkg.sv
// Shared definitions for the systolic PE: mode codes, drain FSM encoding
// and the wide add helper with clamp/wrap and overflow detection.
package pe_pkg;

  localparam logic [1:0] MODE_WS_MAC   = 2'b00;
  localparam logic [1:0] MODE_BYPASS   = 2'b01;
  localparam logic [1:0] MODE_OS_ACC   = 2'b10;
  localparam logic [1:0] MODE_OS_DRAIN = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;

  // Operands arrive sign-extended to this width, so the raw sum never wraps
  // for any accumulator narrower than SUM_W.
  localparam int unsigned SUM_W = 128;

  typedef struct packed {
    logic                    ovf;
    logic signed [SUM_W-1:0] sum;
  } sum_t;

  function automatic sum_t sat_add(input logic signed [SUM_W-1:0] a,
                                   input logic signed [SUM_W-1:0] b,
                                   input int unsigned             width,
                                   input logic                    saturate);
    logic signed [SUM_W-1:0] s;
    logic signed [SUM_W-1:0] hi;
    logic signed [SUM_W-1:0] lo;
    sum_t                    r;
    s     = a + b;
    hi    = (SUM_W'(1) << (width - 1)) - SUM_W'(1);
    lo    = ~hi;
    r.ovf = (s > hi) || (s < lo);
    if (saturate && (s > hi)) begin
      r.sum = hi;
    end else if (saturate && (s < lo)) begin
      r.sum = lo;
    end else begin
      r.sum = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/sys_pe_if.sv
// Neighbour-facing bundle of one systolic PE: activation, partial-sum and
// weight-chain paths plus mode and overflow status.
interface sys_pe_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
);
  logic [DATA_WIDTH-1:0] in_left;
  logic                  in_left_valid;
  logic [ACC_WIDTH-1:0]  in_top;
  logic                  in_top_valid;
  logic [DATA_WIDTH-1:0] w_in;
  logic                  w_shift;
  logic                  w_swap;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] out_right;
  logic                  out_right_valid;
  logic [ACC_WIDTH-1:0]  out_down;
  logic                  out_down_valid;
  logic [DATA_WIDTH-1:0] w_out;
  logic                  ovf;

  modport master (
    output in_left, in_left_valid, in_top, in_top_valid, w_in, w_shift, w_swap, mode,
    input  out_right, out_right_valid, out_down, out_down_valid, w_out, ovf
  );

  modport slave (
    input  in_left, in_left_valid, in_top, in_top_valid, w_in, w_shift, w_swap, mode,
    output out_right, out_right_valid, out_down, out_down_valid, w_out, ovf
  );
endinterface

// File: rtl/pe_mac.sv
// Combinational signed multiply-add: w * x sign-extended and added to a
// partial sum, clamped or wrapped to ACC_WIDTH with an overflow flag.
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic signed [DATA_WIDTH-1:0] w,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [ACC_WIDTH-1:0]  addend,
  output logic signed [ACC_WIDTH-1:0]  sum,
  output logic                         ovf
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  sum_t                           r;
  logic                           unused_sum_hi;

  always_comb begin
    prod = (2*DATA_WIDTH)'(w) * (2*DATA_WIDTH)'(x);
    r    = sat_add(SUM_W'(prod), SUM_W'(addend), ACC_WIDTH, SATURATE);
    sum  = r.sum[ACC_WIDTH-1:0];
    ovf  = r.ovf;
  end

  assign unused_sum_hi = ^r.sum[SUM_W-1:ACC_WIDTH];

endmodule

// File: rtl/sys_pe.sv
// Systolic PE with double-buffered weights, valid propagation, a wide
// (optionally saturating) accumulator and weight/output-stationary modes.
module sys_pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter bit          SATURATE   = 1'b1
) (
  input logic    clk,
  input logic    reset,
  sys_pe_if.slave pe
);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc
    $error("ACC_WIDTH must be at least 2*DATA_WIDTH");
  end
  if (ACC_WIDTH >= SUM_W) begin : g_wide_acc
    $error("ACC_WIDTH exceeds the internal sum width");
  end

  logic signed [DATA_WIDTH-1:0] w_active_q, w_active_d;
  logic signed [DATA_WIDTH-1:0] w_shadow_q, w_shadow_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        out_right_q, out_right_d;
  logic                         out_right_valid_q, out_right_valid_d;
  logic [ACC_WIDTH-1:0]         out_down_q, out_down_d;
  logic                         out_down_valid_q, out_down_valid_d;
  logic                         ovf_q, ovf_d;
  logic [1:0]                   state_q, state_d;

  logic signed [ACC_WIDTH-1:0]  in_top_eff;
  logic signed [ACC_WIDTH-1:0]  ws_sum, acc_sum;
  logic                         ws_ovf, acc_ovf;

  assign in_top_eff = pe.in_top_valid ? pe.in_top : '0;

  pe_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SATURATE   (SATURATE)
  ) u_ws_mac (
    .w      (w_active_q),
    .x      (pe.in_left),
    .addend (in_top_eff),
    .sum    (ws_sum),
    .ovf    (ws_ovf)
  );

  pe_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SATURATE   (SATURATE)
  ) u_acc_mac (
    .w      (w_active_q),
    .x      (pe.in_left),
    .addend (acc_q),
    .sum    (acc_sum),
    .ovf    (acc_ovf)
  );

  always_comb begin
    w_active_d        = w_active_q;
    w_shadow_d        = w_shadow_q;
    acc_d             = acc_q;
    out_down_d        = out_down_q;
    out_down_valid_d  = out_down_valid_q;
    ovf_d             = ovf_q;
    out_right_d       = pe.in_left;
    out_right_valid_d = pe.in_left_valid;

    // Swap reads the pre-shift shadow, so a simultaneous shift+swap commits the old one.
    if (pe.w_shift) w_shadow_d = pe.w_in;
    if (pe.w_swap)  w_active_d = w_shadow_q;

    unique case (pe.mode)
      MODE_WS_MAC: begin
        out_down_valid_d = pe.in_left_valid;
        if (pe.in_left_valid) begin
          out_down_d = ws_sum;
          ovf_d      = ovf_q | ws_ovf;
        end
      end
      MODE_BYPASS: begin
        out_down_d       = pe.in_top;
        out_down_valid_d = pe.in_top_valid;
      end
      MODE_OS_ACC: begin
        out_down_d       = pe.in_top;
        out_down_valid_d = pe.in_top_valid;
        if (pe.in_left_valid) begin
          acc_d = acc_sum;
          ovf_d = ovf_q | acc_ovf;
        end
      end
      MODE_OS_DRAIN: begin
        if (state_q == ST_IDLE) begin
          out_down_d       = acc_q;
          out_down_valid_d = 1'b1;
          acc_d            = '0;
          ovf_d            = 1'b0;
        end else begin
          out_down_d       = pe.in_top;
          out_down_valid_d = pe.in_top_valid;
        end
      end
    endcase
  end

  always_comb begin
    state_d = ST_IDLE;
    if (pe.mode == MODE_OS_DRAIN) begin
      state_d = (state_q == ST_IDLE) ? ST_EMIT : ST_PASS;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_active_q        <= '0;
      w_shadow_q        <= '0;
      acc_q             <= '0;
      out_right_q       <= '0;
      out_right_valid_q <= 1'b0;
      out_down_q        <= '0;
      out_down_valid_q  <= 1'b0;
      ovf_q             <= 1'b0;
      state_q           <= ST_IDLE;
    end else begin
      w_active_q        <= w_active_d;
      w_shadow_q        <= w_shadow_d;
      acc_q             <= acc_d;
      out_right_q       <= out_right_d;
      out_right_valid_q <= out_right_valid_d;
      out_down_q        <= out_down_d;
      out_down_valid_q  <= out_down_valid_d;
      ovf_q             <= ovf_d;
      state_q           <= state_d;
    end
  end

  assign pe.out_right       = out_right_q;
  assign pe.out_right_valid = out_right_valid_q;
  assign pe.out_down        = out_down_q;
  assign pe.out_down_valid  = out_down_valid_q;
  assign pe.w_out           = w_shadow_q;
  assign pe.ovf             = ovf_q;

endmodule

// File: tb/tb_sys_pe.sv
// Bench for sys_pe: a saturating and a wrapping instance share stimulus and
// are checked every cycle against an arithmetic model, plus directed literals.
module tb_sys_pe;

  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_left = '0;
  logic        in_left_valid = 1'b0;
  logic [31:0] in_top = '0;
  logic        in_top_valid = 1'b0;
  logic [15:0] w_in = '0;
  logic        w_shift = 1'b0;
  logic        w_swap = 1'b0;
  logic [1:0]  mode = 2'b01;

  int n_checks = 0;
  int n_fail = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  sys_pe_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) ifs ();
  sys_pe_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) ifw ();

  assign ifs.in_left = in_left;
  assign ifs.in_left_valid = in_left_valid;
  assign ifs.in_top = in_top;
  assign ifs.in_top_valid = in_top_valid;
  assign ifs.w_in = w_in;
  assign ifs.w_shift = w_shift;
  assign ifs.w_swap = w_swap;
  assign ifs.mode = mode;
  assign ifw.in_left = in_left;
  assign ifw.in_left_valid = in_left_valid;
  assign ifw.in_top = in_top;
  assign ifw.in_top_valid = in_top_valid;
  assign ifw.w_in = w_in;
  assign ifw.w_shift = w_shift;
  assign ifw.w_swap = w_swap;
  assign ifw.mode = mode;

  sys_pe #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b1)) dut_sat (
    .clk   (clk),
    .reset (rst_n),
    .pe    (ifs)
  );

  sys_pe #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b0)) dut_wrap (
    .clk   (clk),
    .reset (rst_n),
    .pe    (ifw)
  );

  // Model state; index 0 is the saturating instance, 1 the wrapping one.
  longint m_wa, m_ws, m_or;
  bit     m_orv, m_was_drain;
  longint m_acc[2], m_od[2];
  bit     m_odv[2], m_ovf[2];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sat_fix(input longint s, input bit sat, output bit o);
    longint r;
    o = (s > MAXV) || (s < MINV);
    if (!o) return s;
    if (sat) return (s > MAXV) ? MAXV : MINV;
    r = s & 64'hFFFF_FFFF;
    if (r > MAXV) r = r - 64'sh1_0000_0000;
    return r;
  endfunction

  task automatic model_reset();
    m_wa = 0; m_ws = 0; m_or = 0; m_orv = 0; m_was_drain = 0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_od[k] = 0; m_odv[k] = 0; m_ovf[k] = 0;
    end
  endtask

  task automatic model_step();
    longint x, prod, top, top_eff, s;
    bit o;
    x = longint'($signed(in_left));
    prod = m_wa * x;
    top = longint'($signed(in_top));
    top_eff = in_top_valid ? top : 0;
    for (int k = 0; k < 2; k++) begin
      case (mode)
        2'b00: begin
          m_odv[k] = in_left_valid;
          if (in_left_valid) begin
            m_od[k] = sat_fix(top_eff + prod, k == 0, o);
            if (o) m_ovf[k] = 1;
          end
        end
        2'b01: begin
          m_od[k] = top; m_odv[k] = in_top_valid;
        end
        2'b10: begin
          m_od[k] = top; m_odv[k] = in_top_valid;
          if (in_left_valid) begin
            m_acc[k] = sat_fix(m_acc[k] + prod, k == 0, o);
            if (o) m_ovf[k] = 1;
          end
        end
        default: begin
          if (!m_was_drain) begin
            m_od[k] = m_acc[k]; m_odv[k] = 1; m_acc[k] = 0; m_ovf[k] = 0;
          end else begin
            m_od[k] = top; m_odv[k] = in_top_valid;
          end
        end
      endcase
    end
    m_was_drain = (mode == 2'b11);
    if (w_swap) m_wa_next_swap();
    if (w_shift) m_ws = longint'($signed(w_in));
    m_or = longint'(in_left);
    m_orv = in_left_valid;
  endtask

  // Swap commits the shadow as it was before this cycle's shift.
  task automatic m_wa_next_swap();
    m_wa = m_ws;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic cmp_one(input int k, input logic [15:0] orr, input logic orv,
                         input logic [31:0] od, input logic odv,
                         input logic [15:0] wo, input logic ov);
    string p;
    p = (k == 0) ? "sat" : "wrap";
    chk({p, ".out_right"}, longint'(orr), m_or);
    chk({p, ".out_right_valid"}, longint'(orv), longint'(m_orv));
    chk({p, ".out_down"}, longint'($signed(od)), m_od[k]);
    chk({p, ".out_down_valid"}, longint'(odv), longint'(m_odv[k]));
    chk({p, ".w_out"}, longint'($signed(wo)), m_ws);
    chk({p, ".ovf"}, longint'(ov), longint'(m_ovf[k]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        cmp_one(0, ifs.out_right, ifs.out_right_valid, ifs.out_down, ifs.out_down_valid,
                ifs.w_out, ifs.ovf);
        cmp_one(1, ifw.out_right, ifw.out_right_valid, ifw.out_down, ifw.out_down_valid,
                ifw.w_out, ifw.ovf);
      end
    end
  end

  task automatic step(input logic [1:0] m, input logic lv, input logic [15:0] l,
                      input logic tv, input logic [31:0] t,
                      input logic sh, input logic [15:0] wi, input logic sw);
    mode = m; in_left_valid = lv; in_left = l; in_top_valid = tv; in_top = t;
    w_shift = sh; w_in = wi; w_swap = sw;
    @(negedge clk);
  endtask

  logic [1:0]  r_mode;
  logic [31:0] r_top;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.out_down", longint'(ifs.out_down), 0);
    chk("reset.out_down_valid", longint'(ifs.out_down_valid), 0);
    chk("reset.w_out", longint'(ifs.w_out), 0);
    chk("reset.ovf", longint'(ifw.ovf), 0);
    rst_n = 1'b1;
    run_cmp = 1'b1;

    // Load weight 3 then MAC 10 + 3*5.
    step(2'b01, 0, 16'd0, 0, 32'd0, 1, 16'd3, 0);
    chk("load.w_out", longint'(ifs.w_out), 3);
    step(2'b01, 0, 16'd0, 0, 32'd0, 0, 16'd0, 1);
    step(2'b00, 1, 16'd5, 1, 32'd10, 0, 16'd0, 0);
    chk("ws.out_down", longint'(ifs.out_down), 25);
    chk("ws.out_down_valid", longint'(ifs.out_down_valid), 1);

    // Swap race: active 2, shadow 7, shift 9 + swap + MAC in one cycle.
    step(2'b01, 0, 16'd0, 0, 32'd0, 1, 16'd2, 0);
    step(2'b01, 0, 16'd0, 0, 32'd0, 0, 16'd0, 1);
    step(2'b01, 0, 16'd0, 0, 32'd0, 1, 16'd7, 0);
    step(2'b00, 1, 16'd4, 1, 32'd0, 1, 16'd9, 1);
    chk("race.out_down", longint'(ifs.out_down), 8);
    chk("race.w_out", longint'(ifs.w_out), 9);
    step(2'b00, 1, 16'd1, 1, 32'd0, 0, 16'd0, 0);
    chk("race.new_active", longint'(ifs.out_down), 7);

    // Saturation vs wrap on (-32768)^2 + 0x7FFFFFFF.
    step(2'b01, 0, 16'd0, 0, 32'd0, 1, 16'h8000, 0);
    step(2'b01, 0, 16'd0, 0, 32'd0, 0, 16'd0, 1);
    step(2'b00, 1, 16'h8000, 1, 32'h7FFF_FFFF, 0, 16'd0, 0);
    chk("sat.out_down", longint'(ifs.out_down), 64'h7FFF_FFFF);
    chk("sat.ovf", longint'(ifs.ovf), 1);
    chk("wrap.out_down", longint'(ifw.out_down), 64'hBFFF_FFFF);
    chk("wrap.ovf", longint'(ifw.ovf), 1);

    // Output-stationary accumulate 2*(1+2+3) then drain.
    step(2'b01, 0, 16'd0, 0, 32'd0, 1, 16'd2, 0);
    step(2'b01, 0, 16'd0, 0, 32'd0, 0, 16'd0, 1);
    for (int i = 1; i <= 3; i++) step(2'b10, 1, 16'(i), 0, 32'd0, 0, 16'd0, 0);
    step(2'b11, 1, 16'd9, 1, 32'd77, 0, 16'd0, 0);
    chk("drain.out_down", longint'(ifs.out_down), 12);
    chk("drain.out_down_valid", longint'(ifs.out_down_valid), 1);
    chk("drain.ovf", longint'(ifs.ovf), 0);
    step(2'b11, 1, 16'd9, 1, 32'd77, 0, 16'd0, 0);
    chk("pass.out_down", longint'(ifs.out_down), 77);

    // Bypass valid gaps, then an invalid WS cycle holds out_down.
    step(2'b01, 0, 16'd0, 1, 32'd5, 0, 16'd0, 0);
    chk("byp1.valid", longint'(ifs.out_down_valid), 1);
    step(2'b01, 0, 16'd0, 0, 32'd6, 0, 16'd0, 0);
    chk("byp2.valid", longint'(ifs.out_down_valid), 0);
    step(2'b01, 0, 16'd0, 1, 32'd7, 0, 16'd0, 0);
    chk("byp3.valid", longint'(ifs.out_down_valid), 1);
    step(2'b00, 0, 16'd3, 1, 32'd100, 0, 16'd0, 0);
    chk("wsgap.valid", longint'(ifs.out_down_valid), 0);
    chk("wsgap.hold", longint'(ifs.out_down), 7);

    // Async reset between edges mid-accumulate.
    for (int i = 1; i <= 3; i++) step(2'b10, 1, 16'(i), 1, 32'd55, 0, 16'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_down", longint'(ifs.out_down), 0);
    chk("arst.out_down_valid", longint'(ifs.out_down_valid), 0);
    chk("arst.out_right_valid", longint'(ifs.out_right_valid), 0);
    #1 rst_n = 1'b1;
    step(2'b11, 0, 16'd0, 0, 32'd0, 0, 16'd0, 0);
    chk("arst.drain", longint'(ifs.out_down), 0);
    chk("arst.drain_valid", longint'(ifs.out_down_valid), 1);
    chk("arst.w_out", longint'(ifs.w_out), 0);

    // Random phase with sticky modes, edge-heavy operands and rare resets.
    r_mode = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      case ($urandom_range(0, 2))
        0: r_top = $urandom;
        1: r_top = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
        default: r_top = 32'h8000_0000 + 32'($urandom_range(0, 15));
      endcase
      step(r_mode, 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)),
           r_top, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_pe.md
Name: sys_pe

Overview:
- Parametrised systolic processing element, the successor to the fixed 16-bit weight-stationary PE in the matrix-multiply array.
- Adds a double-buffered weight chain, so the next weights load while the array computes.
- Adds valid propagation, a wide accumulator with optional saturation, and an output-stationary accumulate/drain mode alongside weight-stationary MAC and bypass.
- Instantiated R x C in the array top; activations flow right, partial sums and weights flow down.

Parameters:
- DATA_WIDTH, 16, activation/weight width, two's complement.
- ACC_WIDTH, 40, partial-sum/accumulator width; must be >= 2*DATA_WIDTH (elaboration error otherwise).
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_left  in  DATA_WIDTH  activation from left neighbour.
- in_left_valid  in  1  qualifies in_left.
- in_top  in  ACC_WIDTH  partial sum from PE above.
- in_top_valid  in  1  qualifies in_top.
- w_in  in  DATA_WIDTH  weight chain input from above.
- w_shift  in  1  shadow weight load enable.
- w_swap  in  1  commit shadow weight to active.
- mode  in  2  00 WS_MAC, 01 BYPASS, 10 OS_ACC, 11 OS_DRAIN.
- out_right  out  DATA_WIDTH  registered in_left.
- out_right_valid  out  1  registered in_left_valid.
- out_down  out  ACC_WIDTH  registered partial sum / drained accumulator.
- out_down_valid  out  1  qualifies out_down.
- w_out  out  DATA_WIDTH  shadow weight, to w_in of PE below.
- ovf  out  1  sticky saturation/overflow flag.

Behaviour:
- Reset (reset=0, async):
  - All outputs and internal registers are 0: w_active, w_shadow, acc, out_*, ovf.
  - Drain FSM goes to IDLE.
- Horizontal path: out_right <= in_left and out_right_valid <= in_left_valid every cycle, in all modes; latency 1.
- Weight chain:
  - w_shift=1: w_shadow <= w_in. w_out = w_shadow, so weights advance one PE per cycle.
  - w_swap=1: w_active <= w_shadow.
  - Both set in the same cycle: w_active gets the old w_shadow and w_shadow gets w_in.
  - A MAC in the swap cycle uses the old w_active.
- Arithmetic:
  - prod = signed w_active * signed in_left, 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
  - Sum computed at ACC_WIDTH+1 bits.
  - On overflow: SATURATE=1 clamps to max/min signed and sets ovf; SATURATE=0 wraps and still sets ovf.
  - An invalid in_top operand (in_top_valid=0) is treated as 0.
- WS_MAC (00):
  - If in_left_valid: out_down <= in_top_eff + prod and out_down_valid <= 1.
  - Otherwise: out_down_valid <= 0 and out_down holds.
  - Latency 1.
- BYPASS (01): out_down <= in_top and out_down_valid <= in_top_valid.
- OS_ACC (10):
  - If in_left_valid: acc <= acc + prod (saturating per SATURATE).
  - out_down/out_down_valid forward in_top/in_top_valid, as in BYPASS, so the column drain chain stays intact.
- Drain FSM (OS_DRAIN, 11):
  - States IDLE, EMIT, PASS.
  - IDLE -> EMIT on the first cycle with mode==11. In that cycle: out_down <= acc, out_down_valid <= 1, acc <= 0, ovf <= 0.
  - EMIT -> PASS unconditionally. PASS forwards in_top/in_top_valid as in BYPASS.
  - Any state -> IDLE when mode!=11.
  - in_left_valid is ignored for accumulation while mode==11.
- Mode changes:
  - mode is sampled every cycle.
  - Leaving OS_ACC without draining retains acc.
  - Entering WS_MAC does not clear acc.
- Mid-operation reset clears acc, both weights and the FSM immediately; no partial outputs survive.
- ovf is cleared only by reset or the EMIT cycle.

Decomposition:
- Shared package pe_pkg:
  - mode localparams MODE_WS_MAC/MODE_BYPASS/MODE_OS_ACC/MODE_OS_DRAIN;
  - drain state encoding;
  - function sat_add(a, b, SATURATE) returning the sum plus an overflow bit.
- One sub-module pe_mac: combinational signed multiply, sign-extend and saturating add. It is reused for both the WS sum and the acc update.

Test Plan:
- Weight load/swap: w_in=3 with w_shift for 1 cycle, then w_swap. Next cycle WS_MAC, in_left=5, in_top=10, both valid -> out_down=25, out_down_valid=1 one cycle later; w_out=3.
- Swap race: w_active=2, w_shadow=7; same cycle w_shift (w_in=9) + w_swap + WS_MAC (in_left=4, in_top=0) -> out_down=8; next state w_active=7, w_shadow=9.
- Saturation: SATURATE=1, DATA_WIDTH=16, ACC_WIDTH=32; w=-32768, in_left=-32768, in_top=0x7FFFFFFF -> out_down=0x7FFFFFFF, ovf=1. SATURATE=0 -> wrapped value, ovf=1.
- OS accumulate + drain: w=2; OS_ACC with in_left 1,2,3 valid -> acc=12. mode=11 -> out_down=12, valid=1, acc=0, ovf=0. Next cycle forwards in_top=77/valid -> out_down=77.
- Bypass/valid gaps: BYPASS with in_top_valid toggling 1,0,1 -> out_down_valid mirrors with 1-cycle delay. in_left_valid=0 in WS_MAC -> out_down_valid=0, out_down held.
- Async reset mid-accumulate: acc=12, assert reset between edges -> all outputs 0 immediately; after release, drain emits 0.
